// File: rtl/cx_switch_n.sv
// ---------------------------------------------------------------------------
// cx_switch_n
//   Splits one CXU request stream from the core across NUM_SLAVES CXUs, keyed
//   by s_req_cxu, and merges the CXU responses back onto one response channel
//   with round-robin arbitration. Each slave has an outstanding-request credit
//   limit. Requests addressed to a CXU ID with no slave behind it are answered
//   locally with status ERR_STATUS and data 0.
//
// Handshake rule for every channel: a transfer happens on the rising clock
//   edge where valid && ready. A sender keeps valid and payload stable until
//   that edge; ready may depend combinationally on valid.
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   s_req_*                       upstream request (valid/ready + fields)
//   s_resp_*                      upstream response (registered output slot)
//   m_req_valid/m_req_ready       per-slave request handshake
//   m_req_* fields                request fields broadcast to all slaves
//   m_resp_valid/m_resp_ready     per-slave response handshake
//   m_resp_id/status/data         packed per-slave response fields
//   o_busy                        any request in flight anywhere in the switch
// ---------------------------------------------------------------------------
module cx_switch_n #(
    parameter int                  NUM_SLAVES      = 4,
    parameter int                  CXU_ID_W        = 4,
    parameter int                  REQ_ID_W        = 3,
    parameter int                  STATE_ID_W      = 3,
    parameter int                  FUNC_ID_W       = 10,
    parameter int                  INSN_W          = 32,
    parameter int                  DATA_W          = 32,
    parameter int                  STATUS_W        = 4,
    parameter int                  MAX_OUTSTANDING = 4,
    parameter logic [STATUS_W-1:0] ERR_STATUS      = 4'hF
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           s_req_valid,
    output logic                           s_req_ready,
    input  logic [REQ_ID_W-1:0]            s_req_id,
    input  logic [CXU_ID_W-1:0]            s_req_cxu,
    input  logic [STATE_ID_W-1:0]          s_req_state,
    input  logic [FUNC_ID_W-1:0]           s_req_func,
    input  logic [INSN_W-1:0]              s_req_insn,
    input  logic [DATA_W-1:0]              s_req_data0,
    input  logic [DATA_W-1:0]              s_req_data1,
    output logic                           s_resp_valid,
    input  logic                           s_resp_ready,
    output logic [REQ_ID_W-1:0]            s_resp_id,
    output logic [STATUS_W-1:0]            s_resp_status,
    output logic [DATA_W-1:0]              s_resp_data,
    output logic [NUM_SLAVES-1:0]          m_req_valid,
    input  logic [NUM_SLAVES-1:0]          m_req_ready,
    output logic [REQ_ID_W-1:0]            m_req_id,
    output logic [STATE_ID_W-1:0]          m_req_state,
    output logic [FUNC_ID_W-1:0]           m_req_func,
    output logic [INSN_W-1:0]              m_req_insn,
    output logic [DATA_W-1:0]              m_req_data0,
    output logic [DATA_W-1:0]              m_req_data1,
    input  logic [NUM_SLAVES-1:0]          m_resp_valid,
    output logic [NUM_SLAVES-1:0]          m_resp_ready,
    input  logic [NUM_SLAVES*REQ_ID_W-1:0] m_resp_id,
    input  logic [NUM_SLAVES*STATUS_W-1:0] m_resp_status,
    input  logic [NUM_SLAVES*DATA_W-1:0]   m_resp_data,
    output logic                           o_busy
);

    // Arbiter candidates: slaves 0..NUM_SLAVES-1, local error register last.
    localparam int NCAND = NUM_SLAVES + 1;
    localparam int IDX_W = $clog2(NCAND);
    localparam int CNT_W = 4;

    typedef enum logic {REQ_EMPTY = 1'b0, REQ_FULL = 1'b1} req_state_t;

    req_state_t             req_state, req_state_nxt;
    logic                   full;
    logic [CXU_ID_W-1:0]    sel;
    logic                   sel_ok;
    logic                   req_fire;
    logic                   req_accept;
    logic                   err_take;
    logic [CNT_W-1:0]       credit [NUM_SLAVES];
    logic                   any_credit;
    logic                   err_valid;
    logic [REQ_ID_W-1:0]    err_id;
    logic [IDX_W-1:0]       rr_ptr;
    logic [NCAND-1:0]       cand;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       scan_idx;
    int                     scan;
    logic                   load_en;
    logic                   grant;
    logic                   err_grant;
    logic [REQ_ID_W-1:0]    win_id;
    logic [STATUS_W-1:0]    win_status;
    logic [DATA_W-1:0]      win_data;

    // ---------------- request slot ----------------
    assign full   = (req_state == REQ_FULL);
    // Extra bit so NUM_SLAVES == 2^CXU_ID_W does not wrap to zero.
    assign sel_ok = ({1'b0, sel} < (CXU_ID_W+1)'(NUM_SLAVES));

    always_comb begin
        m_req_valid = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            m_req_valid[k] = full && sel_ok && (sel == CXU_ID_W'(k)) &&
                             (credit[k] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Only the selected slave can be valid, so this is the handshake on sel.
    assign req_fire    = |(m_req_valid & m_req_ready);
    assign err_take    = full && !sel_ok && !err_valid;
    assign s_req_ready = !i_rst && (!full || req_fire);
    assign req_accept  = s_req_valid && s_req_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) req_state <= REQ_EMPTY;
        else       req_state <= req_state_nxt;
    end

    always_comb begin
        req_state_nxt = req_state;
        case (req_state)
            REQ_EMPTY: if (req_accept) req_state_nxt = REQ_FULL;
            REQ_FULL:  if (req_fire || err_take)
                           req_state_nxt = req_accept ? REQ_FULL : REQ_EMPTY;
            default:   req_state_nxt = REQ_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel         <= '0;
            m_req_id    <= '0;
            m_req_state <= '0;
            m_req_func  <= '0;
            m_req_insn  <= '0;
            m_req_data0 <= '0;
            m_req_data1 <= '0;
        end else if (req_accept) begin
            sel         <= s_req_cxu;
            m_req_id    <= s_req_id;
            m_req_state <= s_req_state;
            m_req_func  <= s_req_func;
            m_req_insn  <= s_req_insn;
            m_req_data0 <= s_req_data0;
            m_req_data1 <= s_req_data1;
        end
    end

    // ---------------- credits ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_SLAVES; k++) credit[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if ((m_req_valid[k] && m_req_ready[k]) && !(m_resp_valid[k] && m_resp_ready[k]))
                    credit[k] <= credit[k] + CNT_W'(1);
                else if (!(m_req_valid[k] && m_req_ready[k]) && (m_resp_valid[k] && m_resp_ready[k]))
                    credit[k] <= credit[k] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        any_credit = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) any_credit = any_credit | (credit[k] != '0);
    end

    // ---------------- local error register ----------------
    // Set and clear are exclusive: taking needs err_valid low, granting high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_valid <= 1'b0;
            err_id    <= '0;
        end else if (err_take) begin
            err_valid <= 1'b1;
            err_id    <= m_req_id;
        end else if (err_grant) begin
            err_valid <= 1'b0;
        end
    end

    // ---------------- response arbiter ----------------
    assign cand = {err_valid, m_resp_valid};

    // First valid candidate scanning upward from rr_ptr, wrapping at NCAND.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = 0;
        scan_idx  = '0;
        for (int i = 0; i < NCAND; i++) begin
            scan = int'(rr_ptr) + i;
            if (scan >= NCAND) scan = scan - NCAND;
            scan_idx = IDX_W'(scan);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign load_en   = !s_resp_valid || s_resp_ready;
    assign grant     = load_en && win_found;
    assign err_grant = grant && (win_idx == IDX_W'(NUM_SLAVES));

    always_comb begin
        m_resp_ready = '0;
        win_id       = err_id;
        win_status   = ERR_STATUS;
        win_data     = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (win_idx == IDX_W'(k)) begin
                m_resp_ready[k] = grant;
                win_id          = m_resp_id[k*REQ_ID_W +: REQ_ID_W];
                win_status      = m_resp_status[k*STATUS_W +: STATUS_W];
                win_data        = m_resp_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr        <= '0;
            s_resp_valid  <= 1'b0;
            s_resp_id     <= '0;
            s_resp_status <= '0;
            s_resp_data   <= '0;
        end else if (grant) begin
            rr_ptr        <= err_grant ? '0 : win_idx + IDX_W'(1);
            s_resp_valid  <= 1'b1;
            s_resp_id     <= win_id;
            s_resp_status <= win_status;
            s_resp_data   <= win_data;
        end else if (s_resp_ready) begin
            s_resp_valid  <= 1'b0;
        end
    end

    assign o_busy = full || err_valid || s_resp_valid || any_credit;

endmodule

// File: doc/cx_switch_n.md
Name: cx_switch_n

Overview:
- Parametrised N-way CX switch: splits one CXU request stream from the core across NUM_SLAVES CXUs (e.g. vxu instances), keyed by req_cxu.
- Merges their responses back onto the single CXU response channel using round-robin arbitration.
- Adds per-slave outstanding-request credit limits and local error responses for invalid CXU IDs.
- Sits between the core CXU port and the CXU array, ahead of cx_dma_unit clients.

Parameters:
- NUM_SLAVES, 4, number of downstream CXUs (1..16).
- CXU_ID_W, 4, width of req_cxu; must satisfy 2^CXU_ID_W >= NUM_SLAVES.
- REQ_ID_W, 3, request/response tag width.
- STATE_ID_W, 3, state-context ID width.
- FUNC_ID_W, 10, function ID width.
- INSN_W, 32, raw instruction width.
- DATA_W, 32, operand/result width.
- STATUS_W, 4, response status width.
- MAX_OUTSTANDING, 4, maximum in-flight requests per slave (1..15).
- ERR_STATUS, 4'hF, status value returned for an invalid CXU ID.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- s_req_valid/s_req_ready  in/out  1/1  upstream request handshake
- s_req_id, s_req_cxu, s_req_state, s_req_func, s_req_insn, s_req_data0, s_req_data1  in  REQ_ID_W, CXU_ID_W, STATE_ID_W, FUNC_ID_W, INSN_W, DATA_W, DATA_W  request fields
- s_resp_valid  out  1  upstream response valid
- s_resp_ready  in  1  upstream response ready
- s_resp_id, s_resp_status, s_resp_data  out  REQ_ID_W, STATUS_W, DATA_W  response fields
- m_req_valid  out  NUM_SLAVES  per-slave request valid
- m_req_ready  in  NUM_SLAVES  per-slave request ready
- m_req_id, m_req_state, m_req_func, m_req_insn, m_req_data0, m_req_data1  out  shared bus, widths as upstream  request fields broadcast to all slaves
- m_resp_valid  in  NUM_SLAVES  per-slave response valid
- m_resp_ready  out  NUM_SLAVES  per-slave response ready
- m_resp_id, m_resp_status, m_resp_data  in  NUM_SLAVES×(REQ_ID_W, STATUS_W, DATA_W)  packed per-slave response fields
- o_busy  out  1  any request in flight

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: all valid outputs 0; s_req_ready 0 during reset; all credit counters 0; RR pointer 0; o_busy 0; data outputs 0.
- Request stage, one registered slot (REQ_EMPTY / REQ_FULL):
  - s_req_ready = !full || (m_req_valid[sel] && m_req_ready[sel]).
  - Accepting a request latches all fields plus sel=s_req_cxu; one cycle of latency to m_req_valid.
  - m_req_valid[k] = full && sel==k && sel<NUM_SLAVES && credit[k]<MAX_OUTSTANDING.
  - Back-to-back throughput is 1 per cycle when the slave is ready.
- Credits:
  - credit[k] increments on the m_req handshake and decrements on the m_resp handshake for slave k.
  - A simultaneous increment and decrement leaves the count unchanged.
  - At MAX_OUTSTANDING the slot stalls; it never drops the request.
- Invalid ID (sel>=NUM_SLAVES):
  - The slot is consumed into a one-entry local error register (err_valid, id), provided err_valid is 0; otherwise the slot stalls.
  - The error response carries status ERR_STATUS and data 0.
- Response arbiter:
  - Candidates are m_resp_valid[0..NUM_SLAVES-1] plus err_valid as index NUM_SLAVES.
  - Round-robin starts at rr_ptr; the winner is forwarded into a registered output slot (s_resp_*).
  - m_resp_ready[k] is 1 only for the winner, and only when the output slot is empty or draining (s_resp_ready && s_resp_valid).
  - After a grant, rr_ptr = winner+1, wrapping to 0 after NUM_SLAVES.
  - Response latency is 1 cycle. The output holds stable while s_resp_valid && !s_resp_ready.
- Ordering: no reordering across slaves; per-slave order is preserved.
- o_busy = full || err_valid || s_resp_valid || any credit[k]!=0.
- Reset mid-operation: all in-flight state is discarded; slaves are expected to be reset simultaneously.

Test Plan:
- Single request, cxu=2, id=5, data0=0x1234 → m_req_valid=4'b0100 one cycle later; slave 2 responds id=5, data=0xABCD → s_resp 1 cycle later with id=5, data=0xABCD.
- 5 requests to cxu=1, slave holds responses (MAX_OUTSTANDING=4) → 4 handshakes, 5th stalls with s_req_ready=0; one response releases it next cycle.
- All 4 slaves assert resp_valid continuously with s_resp_ready=1 → grants in order 0,1,2,3,0; each gets one grant per 4 cycles.
- req_cxu=7, id=3 → no m_req_valid; s_resp id=3, status=4'hF, data=0; credits unchanged.
- s_resp_ready held 0 for 10 cycles with slaves valid → s_resp fields stable, m_resp_ready=0; resume → no loss or duplication.
- Reset asserted with 3 in flight → outputs 0 asynchronously, o_busy=0, a new request is accepted after deassertion.
